// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - round-robin key-load sequencer for a shared key-expansion engine
module aes_key_sched_ctrl #(
    parameter int NREQ    = 2,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*128-1:0]   req_key,
    output logic [NREQ-1:0]       req_ack,
    output logic                  kx_start,
    output logic [127:0]          kx_key,
    input  logic                  kx_done,
    input  logic                  blk_issue,
    input  logic                  blk_retire,
    output logic                  pipe_enable,
    output logic                  key_valid,
    output logic [2:0]            active_owner,
    output logic [CNT_W-1:0]      inflight,
    output logic                  err_timeout,
    output logic                  err_proto
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_EMPTY,
        S_ACTIVE,
        S_DRAIN,
        S_LAUNCH,
        S_EXPAND
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        rr_ptr;
    logic [2:0]        grant_q;
    logic [TW-1:0]     tcnt;
    logic              found;
    logic [2:0]        grant_idx;
    logic [127:0]      grant_key;
    logic              grant_take;
    logic              timeout_hit;

    // Two passes: indices at/above rr_ptr first, then the wrapped-around ones.
    always_comb begin
        found     = 1'b0;
        grant_idx = 3'd0;
        grant_key = 128'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j >= int'(rr_ptr))) begin
                found     = 1'b1;
                grant_idx = 3'(j);
                grant_key = req_key[j*128 +: 128];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j < int'(rr_ptr))) begin
                found     = 1'b1;
                grant_idx = 3'(j);
                grant_key = req_key[j*128 +: 128];
            end
        end
    end

    // In ACTIVE the ack cycle is skipped so the just-served requester is not re-granted.
    assign grant_take  = found && ((state == S_EMPTY) ||
                                   ((state == S_ACTIVE) && (req_ack == '0)));
    assign timeout_hit = (state == S_EXPAND) && !kx_done && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY:  if (grant_take) state_nxt = S_LAUNCH;
            S_ACTIVE: if (grant_take) state_nxt = S_DRAIN;
            S_DRAIN:  if ((inflight == '0) && !blk_issue && !blk_retire) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_EXPAND;
            S_EXPAND: begin
                if (kx_done) begin
                    state_nxt = S_ACTIVE;
                end else if (timeout_hit) begin
                    state_nxt = S_EMPTY;
                end
            end
            default:  state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        pipe_enable = 1'b0;
        key_valid   = 1'b0;
        kx_start    = 1'b0;
        case (state)
            S_ACTIVE: begin
                pipe_enable = 1'b1;
                key_valid   = 1'b1;
            end
            S_DRAIN:  key_valid = 1'b1;
            S_LAUNCH: kx_start  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= 3'd0;
            grant_q      <= 3'd0;
            kx_key       <= 128'd0;
            req_ack      <= '0;
            active_owner <= 3'd0;
            tcnt         <= '0;
            inflight     <= '0;
            err_timeout  <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            if (grant_take) begin
                grant_q <= grant_idx;
                kx_key  <= grant_key;
                rr_ptr  <= (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
            end

            req_ack <= '0;
            if ((state == S_EXPAND) && kx_done) begin
                req_ack      <= NREQ'(1) << grant_q;
                active_owner <= grant_q;
            end

            if (state == S_LAUNCH) begin
                tcnt <= '0;
            end else if (state == S_EXPAND) begin
                tcnt <= tcnt + 1'b1;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end

            // Counter saturates at both ends; either saturation is a protocol error.
            if (blk_issue && !blk_retire) begin
                if (inflight == CNT_MAX) begin
                    err_proto <= 1'b1;
                end else begin
                    inflight <= inflight + 1'b1;
                end
            end else if (!blk_issue && blk_retire) begin
                if (inflight == '0) begin
                    err_proto <= 1'b1;
                end else begin
                    inflight <= inflight - 1'b1;
                end
            end
            if (blk_issue && !pipe_enable) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    localparam int NREQ  = 2;
    localparam int CNT_W = 5;
    localparam logic [127:0] KEY_A = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] KEY_B = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*128-1:0]   req_key;
    logic [NREQ-1:0]       req_ack;
    logic                  kx_start;
    logic [127:0]          kx_key;
    logic                  kx_done;
    logic                  blk_issue;
    logic                  blk_retire;
    logic                  pipe_enable;
    logic                  key_valid;
    logic [2:0]            active_owner;
    logic [CNT_W-1:0]      inflight;
    logic                  err_timeout;
    logic                  err_proto;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic             issue;
        logic             retire;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_err;
    } vec_t;

    vec_t tbl [6];

    aes_key_sched_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_key      (req_key),
        .req_ack      (req_ack),
        .kx_start     (kx_start),
        .kx_key       (kx_key),
        .kx_done      (kx_done),
        .blk_issue    (blk_issue),
        .blk_retire   (blk_retire),
        .pipe_enable  (pipe_enable),
        .key_valid    (key_valid),
        .active_owner (active_owner),
        .inflight     (inflight),
        .err_timeout  (err_timeout),
        .err_proto    (err_proto)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req        = '0;
        kx_done    = 1'b0;
        blk_issue  = 1'b0;
        blk_retire = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_start(input int bound);
        int k = 0;
        while (!kx_start && k < bound) begin
            step();
            k++;
        end
        chk("kx_start_seen", 128'(kx_start), 128'd1);
    endtask

    // Entered while kx_start is high; engine answers dly cycles later.
    task automatic finish_load(input int dly, input logic [1:0] exp_ack,
                               input logic [2:0] exp_own, input logic [127:0] exp_key,
                               input bit drop);
        chk("kx_key", kx_key, exp_key);
        step();
        chk("kx_start_one_cycle", 128'(kx_start), 128'd0);
        repeat (dly - 1) step();
        kx_done = 1'b1;
        step();
        kx_done = 1'b0;
        chk("req_ack", 128'(req_ack), 128'(exp_ack));
        chk("pipe_enable_after_done", 128'(pipe_enable), 128'd1);
        chk("key_valid_after_done", 128'(key_valid), 128'd1);
        chk("active_owner", 128'(active_owner), 128'(exp_own));
        if (drop) req = req & ~exp_ack;
        step();
        chk("req_ack_pulse_end", 128'(req_ack), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ack_seen;
        tbl[0] = '{1'b1, 1'b0, 5'd1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 5'd2, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 5'd2, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 5'd1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 5'd2, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 5'd3, 1'b0};
        req_key = {KEY_B, KEY_A};

        do_reset();
        chk("rst_req_ack", 128'(req_ack), 128'd0);
        chk("rst_kx_start", 128'(kx_start), 128'd0);
        chk("rst_kx_key", kx_key, 128'd0);
        chk("rst_pipe_enable", 128'(pipe_enable), 128'd0);
        chk("rst_key_valid", 128'(key_valid), 128'd0);
        chk("rst_inflight", 128'(inflight), 128'd0);
        chk("rst_errs", 128'({err_timeout, err_proto}), 128'd0);

        // First load: kx_start exactly one cycle after the request is sampled.
        req = 2'b01;
        step();
        chk("launch_latency", 128'(kx_start), 128'd1);
        finish_load(12, 2'b01, 3'd0, KEY_A, 1'b1);

        for (int i = 0; i < 6; i++) begin
            blk_issue  = tbl[i].issue;
            blk_retire = tbl[i].retire;
            step();
            blk_issue  = 1'b0;
            blk_retire = 1'b0;
            chk($sformatf("cnt_vec%0d", i), 128'(inflight), 128'(tbl[i].exp_cnt));
            chk($sformatf("err_vec%0d", i), 128'(err_proto), 128'(tbl[i].exp_err));
        end

        // Key swap with three blocks in flight.
        req = 2'b10;
        step();
        chk("drain_pipe_off", 128'(pipe_enable), 128'd0);
        chk("drain_key_valid", 128'(key_valid), 128'd1);
        chk("drain_no_start", 128'(kx_start), 128'd0);
        blk_retire = 1'b1;
        step();
        step();
        step();
        blk_retire = 1'b0;
        chk("drain_cnt_zero", 128'(inflight), 128'd0);
        chk("drain_still_no_start", 128'(kx_start), 128'd0);
        step();
        chk("drain_launch", 128'(kx_start), 128'd1);
        finish_load(4, 2'b10, 3'd1, KEY_B, 1'b1);

        blk_retire = 1'b1;
        step();
        blk_retire = 1'b0;
        chk("underflow_cnt", 128'(inflight), 128'd0);
        chk("underflow_err", 128'(err_proto), 128'd1);

        do_reset();
        chk("rst_clears_proto", 128'(err_proto), 128'd0);
        blk_issue = 1'b1;
        step();
        blk_issue = 1'b0;
        chk("issue_off_cnt", 128'(inflight), 128'd1);
        chk("issue_off_err", 128'(err_proto), 128'd1);

        // Saturation at 2^CNT_W-1.
        do_reset();
        req = 2'b01;
        step();
        chk("sat_launch", 128'(kx_start), 128'd1);
        finish_load(2, 2'b01, 3'd0, KEY_A, 1'b1);
        blk_issue = 1'b1;
        repeat (31) step();
        blk_issue = 1'b0;
        chk("sat_full_cnt", 128'(inflight), 128'd31);
        chk("sat_full_err", 128'(err_proto), 128'd0);
        blk_issue = 1'b1;
        step();
        blk_issue = 1'b0;
        chk("sat_over_cnt", 128'(inflight), 128'd31);
        chk("sat_over_err", 128'(err_proto), 128'd1);

        // Both requesters held: grants alternate.
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_start(12);
            if (i % 2 == 0) finish_load(3, 2'b01, 3'd0, KEY_A, 1'b0);
            else            finish_load(3, 2'b10, 3'd1, KEY_B, 1'b0);
        end
        req = '0;

        // Engine never answers.
        do_reset();
        req = 2'b01;
        step();
        chk("to_launch", 128'(kx_start), 128'd1);
        ack_seen = 1'b0;
        repeat (64) begin
            step();
            if (req_ack != '0) ack_seen = 1'b1;
        end
        chk("to_not_yet", 128'(err_timeout), 128'd0);
        step();
        if (req_ack != '0) ack_seen = 1'b1;
        chk("to_flag", 128'(err_timeout), 128'd1);
        chk("to_key_valid", 128'(key_valid), 128'd0);
        chk("to_pipe_enable", 128'(pipe_enable), 128'd0);
        chk("to_no_ack", 128'(ack_seen), 128'd0);
        step();
        chk("to_relaunch", 128'(kx_start), 128'd1);
        finish_load(5, 2'b01, 3'd0, KEY_A, 1'b1);
        chk("to_sticky", 128'(err_timeout), 128'd1);

        // Reset in the middle of an expansion.
        blk_retire = 1'b1;
        step();
        blk_retire = 1'b0;
        chk("pre_rst_proto", 128'(err_proto), 128'd1);
        req = 2'b10;
        wait_start(12);
        step();
        step();
        reset = 1'b1;
        req   = '0;
        step();
        chk("mid_rst_kx_key", kx_key, 128'd0);
        chk("mid_rst_outs", 128'({req_ack, kx_start, pipe_enable, key_valid, active_owner}), 128'd0);
        chk("mid_rst_errs", 128'({err_timeout, err_proto}), 128'd0);
        chk("mid_rst_inflight", 128'(inflight), 128'd0);
        reset   = 1'b0;
        kx_done = 1'b1;
        step();
        kx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_done_ack", 128'(req_ack), 128'd0);
            chk("stray_done_kv", 128'(key_valid), 128'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
